bmf_approx_pipe: RTL and testbench
==================================

Name: bmf_approx_pipe

Overview:
- Runtime-programmable Boolean-matrix-factorisation (BMF) approximate-logic block; the parametrised, pipelined successor of the fixed k=3 compressor/decompressor pairs in the mult16 partitions.
- Compressor W is a loadable LUT mapping each N_IN-bit input pattern to K_MAX factor bits.
- Decompressor H forms each output as the OR over active factors j of (k_j AND H[j][i]), with runtime-selectable rank.
- Sits between partition boundaries, with valid/ready streaming and a config port for reloading factorisations without resynthesis.

Parameters:
N_IN, 9, input pattern width (LUT depth 2^N_IN)
N_OUT, 4, output width
K_MAX, 3, maximum factorisation rank
CFG_W, 9, config data/address width; must be >= max(N_IN, K_MAX, N_OUT, clog2(K_MAX+1))
CNT_W, 16, beat counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  N_IN  input pattern (pi vector)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  N_OUT  approximate outputs (po vector)
out_k  out  K_MAX  rank-masked factor bits of the beat in out_data
cfg_we  in  1  config write strobe
cfg_sel  in  2  0=W entry, 1=H row, 2=rank, 3=clear beat counter
cfg_addr  in  CFG_W  W: pattern index; H: factor index j
cfg_wdata  in  CFG_W  write data (LSB-aligned)
cfg_ready  out  1  config write accepted when cfg_we & cfg_ready
rank  out  clog2(K_MAX+1)  current active rank
beat_cnt  out  CNT_W  delivered output beats, saturating

Behaviour:
- Async reset:
  - all W entries = 0; all H rows = 0; rank = K_MAX; beat_cnt = 0.
  - Pipeline valids = 0; out_data = 0; out_k = 0; out_valid = 0.
  - in_ready = 0 while rst_n is low. After release, in_ready = 1 and cfg_ready = 1.
- Pipeline: two stages, latency exactly 2 cycles with no backpressure.
  - S1 registers k = W[in_data] & mask(rank), where mask has bits j < rank set.
  - S2 registers out_k = k and out_data[i] = OR_j(k[j] & H[j][i]).
- Handshake:
  - S2 holds out_data/out_k/out_valid stable while out_valid & !out_ready.
  - S1 advances when S2 is empty or drains this cycle.
  - in_ready = !cfg_we & (!s1_valid | s1_advances). Full throughput of 1 beat/cycle with out_ready held high.
  - No beat is dropped or duplicated under any out_ready pattern.
- Config:
  - cfg_ready = !s1_valid & !s2_valid; writes apply only when the pipeline is drained.
  - cfg_we has priority over in_valid in the same cycle: in_ready is forced low and the config write is taken.
  - cfg_we with cfg_ready low is ignored and produces no state change; the master holds cfg_we until cfg_ready.
  - sel 0: W[cfg_addr[N_IN-1:0]] <= cfg_wdata[K_MAX-1:0].
  - sel 1: if cfg_addr < K_MAX, H[cfg_addr] <= cfg_wdata[N_OUT-1:0]; otherwise ignored.
  - sel 2: rank <= min(cfg_wdata, K_MAX). Rank 0 yields all-zero outputs.
  - sel 3: beat_cnt <= 0.
  - A written value affects only beats accepted after the write cycle.
- beat_cnt:
  - Increments on out_valid & out_ready.
  - Saturates at 2^CNT_W-1, with no wrap.
  - If sel 3 coincides with a delivered beat, the clear wins.
- Reset mid-stream: in-flight beats are discarded and the tables are reloaded to reset values. No output is produced until new input arrives.

Test Plan:
- Reset, then stream 9'h000..9'h1FF, out_ready=1 -> every out_data=4'h0 and out_k=0, first out_valid 2 cycles after the first accept, beat_cnt=512.
- Write W[9'h1FF]=3'b101, H0=4'b0001, H1=4'b0110, H2=4'b1000, then send 9'h1FF -> out_k=3'b101, out_data=4'b1001.
- Same tables, rank=1 then 9'h1FF -> out_data=4'b0001 and out_k=3'b001. Rank written as 7 -> rank=3 and out_data=4'b1001. Rank=0 -> out_data=0.
- Random out_ready toggling over 1000 random beats against a reference model -> identical ordered output stream, out_data stable while stalled, beat_cnt=1000.
- Assert cfg_we with in_valid while a beat is in flight -> cfg_ready=0 and write ignored until drain. When cfg_we and in_valid arrive together in the drained state, in_ready=0 and the write lands; the next beat uses the new table.
- Pulse rst_n low while S1 and S2 are valid -> out_valid=0 immediately, W/H cleared, rank=3, beat_cnt=0. After release, 9'h1FF -> out_data=0.

Source files
------------

// File: rtl/bmf_approx_pipe.sv
// bmf_approx_pipe
//   Runtime-programmable Boolean-matrix-factorisation approximate-logic block.
//   A loadable compressor LUT W maps each N_IN-bit input pattern to K_MAX
//   factor bits. A decompressor H forms each output bit as the OR over active
//   factors j of (k[j] & H[j][i]). The active rank masks off factors j >= rank.
//   Two-stage valid/ready pipeline. A config port reloads W/H/rank while the
//   pipeline is drained.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input beat handshake, in_data = input pattern
//   out_valid/out_ready   output beat handshake
//   out_data              approximate outputs
//   out_k                 rank-masked factor bits of the beat in out_data
//   cfg_we/cfg_ready      config write handshake; cfg_we blocks new input beats
//   cfg_sel               0 = W entry, 1 = H row, 2 = rank, 3 = clear beat_cnt
//   cfg_addr, cfg_wdata   W pattern index / H factor index, LSB-aligned data
//   rank                  current active rank
//   beat_cnt              delivered output beats, saturating
module bmf_approx_pipe #(
  parameter int N_IN  = 9,
  parameter int N_OUT = 4,
  parameter int K_MAX = 3,
  parameter int CFG_W = 9,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN-1:0]              in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OUT-1:0]             out_data,
  output logic [K_MAX-1:0]             out_k,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_sel,
  input  logic [CFG_W-1:0]             cfg_addr,
  input  logic [CFG_W-1:0]             cfg_wdata,
  output logic                         cfg_ready,
  output logic [$clog2(K_MAX+1)-1:0]   rank,
  output logic [CNT_W-1:0]             beat_cnt
);

  localparam int RK_W  = $clog2(K_MAX + 1);
  localparam int DEPTH = 2 ** N_IN;

  // Clamp a written rank to K_MAX.
  function automatic logic [RK_W-1:0] clamp_rank(input logic [CFG_W-1:0] v);
    if (v > CFG_W'(K_MAX)) return RK_W'(K_MAX);
    return v[RK_W-1:0];
  endfunction

  // Saturating increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [K_MAX-1:0] w_q [DEPTH];
  logic [N_OUT-1:0] h_q [K_MAX];
  logic [RK_W-1:0]  rank_q;
  logic [CNT_W-1:0] cnt_q;

  logic             vld_p1_q;
  logic [K_MAX-1:0] k_p1_q;
  logic [K_MAX-1:0] k_p1_d;
  logic             vld_p2_q;
  logic [K_MAX-1:0] k_p2_q;
  logic [N_OUT-1:0] data_p2_q;
  logic [N_OUT-1:0] data_p2_d;
  logic [K_MAX-1:0] rank_mask;

  logic s2_free;
  logic s1_load;
  logic accept;
  logic cfg_fire;
  logic deliver;

  // S2 can take a beat when empty or when its beat leaves this cycle; S1 in turn.
  assign s2_free   = !vld_p2_q || out_ready;
  assign s1_load   = !vld_p1_q || s2_free;
  assign in_ready  = rst_n && !cfg_we && s1_load;
  assign accept    = in_valid && in_ready;
  assign cfg_ready = !vld_p1_q && !vld_p2_q;
  assign cfg_fire  = cfg_we && cfg_ready;
  assign deliver   = vld_p2_q && out_ready;

  always_comb begin
    rank_mask = '0;
    for (int j = 0; j < K_MAX; j++) begin
      if (rank_q > RK_W'(j)) rank_mask[j] = 1'b1;
    end
    k_p1_d = w_q[in_data] & rank_mask;
    data_p2_d = '0;
    for (int j = 0; j < K_MAX; j++) begin
      if (k_p1_q[j]) data_p2_d = data_p2_d | h_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      k_p1_q    <= '0;
      vld_p2_q  <= 1'b0;
      k_p2_q    <= '0;
      data_p2_q <= '0;
    end else begin
      // Stage 1: compress through W and mask by rank
      if (s1_load) begin
        vld_p1_q <= accept;
        if (accept) k_p1_q <= k_p1_d;
      end
      // Stage 2: decompress through H; held while stalled
      if (s2_free) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          k_p2_q    <= k_p1_q;
          data_p2_q <= data_p2_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) w_q[a] <= '0;
      for (int j = 0; j < K_MAX; j++) h_q[j] <= '0;
      rank_q <= RK_W'(K_MAX);
    end else if (cfg_fire) begin
      case (cfg_sel)
        2'd0: w_q[cfg_addr[N_IN-1:0]] <= cfg_wdata[K_MAX-1:0];
        2'd1: begin
          // Out-of-range factor indices fall through and are ignored.
          for (int j = 0; j < K_MAX; j++) begin
            if (cfg_addr == CFG_W'(j)) h_q[j] <= cfg_wdata[N_OUT-1:0];
          end
        end
        2'd2: rank_q <= clamp_rank(cfg_wdata);
        default: ;
      endcase
    end
  end

  // Clear request beats a coincident delivered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cfg_fire && cfg_sel == 2'd3) begin
      cnt_q <= '0;
    end else if (deliver) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_k     = k_p2_q;
  assign rank      = rank_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_bmf_approx_pipe.sv
module tb_bmf_approx_pipe;
  localparam int N_IN = 9, N_OUT = 4, K_MAX = 3, CFG_W = 9, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready;
  logic [N_IN-1:0] in_data;
  logic out_valid, out_ready;
  logic [N_OUT-1:0] out_data;
  logic [K_MAX-1:0] out_k;
  logic cfg_we, cfg_ready;
  logic [1:0] cfg_sel;
  logic [CFG_W-1:0] cfg_addr, cfg_wdata;
  logic [1:0] rank;
  logic [CNT_W-1:0] beat_cnt;
  logic rnd_en;

  bmf_approx_pipe #(.N_IN(N_IN), .N_OUT(N_OUT), .K_MAX(K_MAX), .CFG_W(CFG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_k(out_k),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .rank(rank), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: tables, rank, delivered count, expected beat queue.
  typedef struct packed {logic [2:0] k; logic [3:0] d;} beat_t;
  logic [2:0] mw [512];
  logic [3:0] mh [3];
  int mrank;
  int mcnt;
  beat_t q[$];

  task automatic model_reset();
    for (int a = 0; a < 512; a++) mw[a] = 3'b000;
    for (int j = 0; j < 3; j++) mh[j] = 4'b0000;
    mrank = 3;
    mcnt = 0;
    q.delete();
  endtask

  function automatic beat_t model_beat(input logic [8:0] x);
    beat_t b;
    b.k = mw[x] & 3'((1 << mrank) - 1);
    b.d = 4'b0000;
    for (int j = 0; j < 3; j++) if (b.k[j]) b.d = b.d | mh[j];
    return b;
  endfunction

  // Compare process: samples on the falling edge, mirrors the next rising edge.
  initial begin
    logic prev_stall;
    logic [2:0] pk;
    logic [3:0] pd;
    beat_t e;
    prev_stall = 1'b0;
    pk = '0;
    pd = '0;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        prev_stall = 1'b0;
      end else begin
        chk("beat_cnt", beat_cnt, mcnt);
        chk("rank", rank, mrank);
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_hold", {out_k, out_data}, {pk, pd});
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("spurious_beat", 1, 0);
          end else begin
            e = q.pop_front();
            chk("beat_data", out_data, e.d);
            chk("beat_k", out_k, e.k);
          end
          if (mcnt < 65535) mcnt++;
        end
        if (cfg_we && cfg_ready) begin
          case (cfg_sel)
            2'd0: mw[cfg_addr[8:0]] = cfg_wdata[2:0];
            2'd1: if (cfg_addr < 3) mh[cfg_addr[1:0]] = cfg_wdata[3:0];
            2'd2: mrank = (cfg_wdata > 3) ? 3 : int'(cfg_wdata);
            default: mcnt = 0;
          endcase
        end
        if (in_valid && in_ready) q.push_back(model_beat(in_data));
        prev_stall = out_valid && !out_ready;
        pk = out_k;
        pd = out_data;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [8:0] x);
    int n;
    in_valid = 1'b1;
    in_data = x;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [3:0] d, output logic [2:0] k);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("out_timeout", 0, 1);
    d = out_data;
    k = out_k;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [8:0] addr, input logic [8:0] wd);
    int n;
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_addr = addr;
    cfg_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("cfg_timeout", 0, 1);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!cfg_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    logic [3:0] d;
    logic [2:0] k;
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_sel = '0;
    cfg_addr = '0;
    cfg_wdata = '0;
    rnd_en = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_k", out_k, 0);
    chk("rst_rank", rank, 3);
    chk("rst_beat_cnt", beat_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_cfg_ready", cfg_ready, 1);
    @(posedge clk);
    #1;

    // Full sweep with reset tables, plus first-beat latency
    send(9'h000);
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 2);
    chk("sweep_first_data", out_data, 0);
    for (int i = 1; i < 512; i++) send(9'(i));
    drain();
    chk("sweep_cnt", beat_cnt, 512);

    // Directed factorisation
    cfg_write(2'd0, 9'h1FF, 9'b101);
    cfg_write(2'd1, 9'd0, 9'b0001);
    cfg_write(2'd1, 9'd1, 9'b0110);
    cfg_write(2'd1, 9'd2, 9'b1000);
    send(9'h1FF);
    wait_out(d, k);
    chk("full_rank_data", d, 4'b1001);
    chk("full_rank_k", k, 3'b101);

    cfg_write(2'd2, 9'd0, 9'd1);
    chk("rank1_reg", rank, 1);
    send(9'h1FF);
    wait_out(d, k);
    chk("rank1_data", d, 4'b0001);
    chk("rank1_k", k, 3'b001);

    cfg_write(2'd2, 9'd0, 9'd7);
    chk("rank_clamp", rank, 3);
    cfg_write(2'd1, 9'd3, 9'hF);
    send(9'h1FF);
    wait_out(d, k);
    chk("clamped_data", d, 4'b1001);

    cfg_write(2'd2, 9'd0, 9'd0);
    send(9'h1FF);
    wait_out(d, k);
    chk("rank0_data", d, 4'b0000);
    chk("rank0_k", k, 3'b000);
    cfg_write(2'd2, 9'd0, 9'd3);

    // Random beats under random backpressure
    cfg_write(2'd3, 9'd0, 9'd0);
    chk("cnt_clear", beat_cnt, 0);
    for (int a = 0; a < 512; a++) cfg_write(2'd0, 9'(a), 9'($urandom_range(0, 7)));
    for (int j = 0; j < 3; j++) cfg_write(2'd1, 9'(j), 9'($urandom_range(0, 15)));
    for (int ph = 0; ph < 2; ph++) begin
      rnd_en = 1'b1;
      for (int i = 0; i < 500; i++) begin
        send(9'($urandom_range(0, 511)));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      rnd_en = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
      if (ph == 0) cfg_write(2'd2, 9'd0, 9'd2);
    end
    chk("random_cnt", beat_cnt, 1000);

    // Config priority and busy-pipeline write blocking
    cfg_write(2'd2, 9'd0, 9'd3);
    cfg_write(2'd0, 9'h1FF, 9'b101);
    cfg_write(2'd1, 9'd0, 9'b0001);
    cfg_write(2'd1, 9'd1, 9'b0110);
    cfg_write(2'd1, 9'd2, 9'b1000);
    out_ready = 1'b0;
    send(9'h1FF);
    send(9'h1FF);
    cfg_we = 1'b1;
    cfg_sel = 2'd1;
    cfg_addr = 9'd0;
    cfg_wdata = 9'hF;
    in_valid = 1'b1;
    in_data = 9'h1FF;
    @(negedge clk);
    chk("busy_cfg_ready", cfg_ready, 0);
    chk("busy_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("held_a_data", out_data, 4'b1001);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("held_b_data", out_data, 4'b1001);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drained_cfg_ready", cfg_ready, 1);
    chk("prio_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    @(negedge clk);
    chk("after_cfg_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(d, k);
    chk("new_table_data", d, 4'b1111);

    // Reset with both stages full
    send(9'h1FF);
    send(9'h0AA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_rank", rank, 3);
    chk("midrst_cnt", beat_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_quiet", out_valid, 0);
    end
    send(9'h1FF);
    wait_out(d, k);
    chk("midrst_data", d, 4'b0000);
    chk("midrst_k", k, 3'b000);
    drain();
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
